// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl_if : control-unit bundle (IR/flags in, datapath/memory out)
// Revision 1.0
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic [3:0]       opcode;
  logic             zero;
  logic             memAck;
  logic             memReq;
  logic             memWe;
  logic             iOrD;
  logic             irWrite;
  logic             pcWrite;
  logic [1:0]       pcSrc;
  logic [2:0]       aluOp;
  logic [1:0]       aluSrc1;
  logic [1:0]       aluSrc2;
  logic [1:0]       regDst;
  logic [1:0]       memToReg;
  logic             regWrite;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             halted;
  logic             fault;
  logic [2:0]       state;

  modport master (
    input  opcode, zero, memAck,
    output memReq, memWe, iOrD, irWrite, pcWrite, pcSrc, aluOp, aluSrc1,
           aluSrc2, regDst, memToReg, regWrite, retire, instret, halted,
           fault, state
  );

  modport slave (
    output opcode, zero, memAck,
    input  memReq, memWe, iOrD, irWrite, pcWrite, pcSrc, aluOp, aluSrc1,
           aluSrc2, regDst, memToReg, regWrite, retire, instret, halted,
           fault, state
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_ctrl : multi-cycle FSM control unit with req/ack memory port
// Revision 1.0
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int         TIMEOUT  = 15,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] LINK_DST = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  localparam logic [3:0] OP_ADI = 4'b1000;
  localparam logic [3:0] OP_SWP = 4'b1001;
  localparam logic [3:0] OP_LDW = 4'b1010;
  localparam logic [3:0] OP_STW = 4'b1011;
  localparam logic [3:0] OP_BRZ = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;
  localparam logic [3:0] OP_JAL = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_FAULT   = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_op;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instret;

  logic       w_timeout;
  logic       w_memReq, w_memWe, w_iOrD, w_irWrite, w_pcWrite, w_regWrite, w_retire;
  logic [1:0] w_pcSrc, w_aluSrc1, w_aluSrc2, w_regDst, w_memToReg;
  logic [2:0] w_aluOp;

  // {aluOp, aluSrc1, aluSrc2}; shared by EXEC and the MEM/WB states that hold it
  function automatic logic [6:0] alu_ctrl(input logic [3:0] op);
    logic [6:0] c;
    c = 7'd0;
    if (!op[3])                          c = {op[2:0], 2'b00, 2'b00};
    else if (op == OP_ADI)               c = {3'b000, 2'b00, 2'b01};
    else if (op == OP_SWP)               c = {3'b000, 2'b10, 2'b10};
    else if (op == OP_LDW || op == OP_STW) c = {3'b000, 2'b00, 2'b01};
    else if (op == OP_BRZ)               c = {3'b001, 2'b00, 2'b00};
    return c;
  endfunction

  assign w_timeout = (TIMEOUT != 0) && (r_wait == WAIT_MAX);

  always_comb begin
    w_next     = r_state;
    w_memReq   = 1'b0;
    w_memWe    = 1'b0;
    w_iOrD     = 1'b0;
    w_irWrite  = 1'b0;
    w_pcWrite  = 1'b0;
    w_pcSrc    = 2'b00;
    w_aluOp    = 3'b000;
    w_aluSrc1  = 2'b00;
    w_aluSrc2  = 2'b00;
    w_regDst   = 2'b00;
    w_memToReg = 2'b00;
    w_regWrite = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memReq = 1'b1;
        if (bus.memAck) begin
          w_irWrite = 1'b1;
          w_pcWrite = 1'b1;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_HLT: w_next = S_HALT;
          OP_JMP: begin
            w_pcWrite = 1'b1;
            w_pcSrc   = 2'b10;
            w_next    = S_FETCH;
          end
          OP_JAL: begin
            // PC already holds PC+1 from FETCH, so it is the link value
            w_pcWrite  = 1'b1;
            w_pcSrc    = 2'b10;
            w_regWrite = 1'b1;
            w_regDst   = LINK_DST;
            w_memToReg = 2'b10;
            w_next     = S_FETCH;
          end
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        {w_aluOp, w_aluSrc1, w_aluSrc2} = alu_ctrl(r_op);
        if (r_op == OP_LDW || r_op == OP_STW) begin
          w_next = S_MEM;
        end else if (r_op == OP_BRZ) begin
          if (bus.zero) begin
            w_pcWrite = 1'b1;
            w_pcSrc   = 2'b01;
          end
          w_next = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        {w_aluOp, w_aluSrc1, w_aluSrc2} = alu_ctrl(r_op);
        w_memReq = 1'b1;
        w_iOrD   = 1'b1;
        w_memWe  = (r_op == OP_STW);
        if (bus.memAck)  w_next = (r_op == OP_STW) ? S_FETCH : S_WB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_WB: begin
        {w_aluOp, w_aluSrc1, w_aluSrc2} = alu_ctrl(r_op);
        w_regWrite = 1'b1;
        w_memToReg = (r_op == OP_LDW) ? 2'b01 : 2'b00;
        w_next     = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FETCH;
    endcase

    w_retire = ((w_next == S_FETCH) &&
                (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB})) ||
               ((w_next == S_HALT) && (r_state != S_HALT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= 4'd0;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= bus.opcode;
      if (w_next != r_state)
        r_wait <= '0;
      else if ((r_state == S_FETCH || r_state == S_MEM) && !bus.memAck)
        r_wait <= r_wait + 1'b1;
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end

  // Outputs are gated by rst so the memory request drops in the reset cycle itself
  assign bus.memReq   = w_memReq   & ~rst;
  assign bus.memWe    = w_memWe    & ~rst;
  assign bus.iOrD     = w_iOrD     & ~rst;
  assign bus.irWrite  = w_irWrite  & ~rst;
  assign bus.pcWrite  = w_pcWrite  & ~rst;
  assign bus.regWrite = w_regWrite & ~rst;
  assign bus.retire   = w_retire   & ~rst;
  assign bus.pcSrc    = rst ? 2'b00 : w_pcSrc;
  assign bus.aluOp    = rst ? 3'b000 : w_aluOp;
  assign bus.aluSrc1  = rst ? 2'b00 : w_aluSrc1;
  assign bus.aluSrc2  = rst ? 2'b00 : w_aluSrc2;
  assign bus.regDst   = rst ? 2'b00 : w_regDst;
  assign bus.memToReg = rst ? 2'b00 : w_memToReg;
  assign bus.instret  = rst ? '0 : r_instret;
  assign bus.halted   = ~rst & (r_state == S_HALT);
  assign bus.fault    = ~rst & (r_state == S_FAULT);
  assign bus.state    = rst ? 3'd0 : r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle FSM control unit for the 16-bit, 4-bit-opcode Subarashii core. It replaces the single-cycle combinational decoder. The block sequences each instruction through fetch, decode, execute, memory and writeback, and handshakes with a single shared memory port using a req/ack pair. It also provides a bus-timeout fault, a halt state and a retired-instruction counter. It sits between the instruction register/ALU flags and the datapath muxes, register file and memory port.

## Interface
- TIMEOUT, 15: max cycles spent waiting for memAck in FETCH or MEM; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.
- LINK_DST, 2'b10: regDst encoding that selects the JAL link register.

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  4  IR[15:12]; valid from DECODE onward
- zero  in  1  ALU zero flag, used by BRZ
- memAck  in  1  memory completes the current request this cycle
- memReq  out  1  memory request
- memWe  out  1  write enable, valid while memReq=1
- iOrD  out  1  address select: 0 = PC, 1 = ALU result
- irWrite  out  1  load IR from memory data
- pcWrite  out  1  load PC
- pcSrc  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target
- aluOp  out  3  ALU operation
- aluSrc1  out  2  operand 1 source: 00 = Rs, 10 = Rs[HI]
- aluSrc2  out  2  operand 2 source: 00 = Rt, 01 = imm, 10 = Rt[LO]
- regDst  out  2  register write destination
- memToReg  out  2  write-back data source: 00 = ALU, 01 = memory, 10 = PC
- regWrite  out  1  register file write
- retire  out  1  one-cycle pulse when an instruction completes
- instret  out  CNT_W  count of retired instructions
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- state  out  3  debug: current state encoding

## Operation
- State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5, FAULT = 6. Encoding 7 is illegal and returns to FETCH.
- All outputs are 0 unless stated below. Control outputs are decoded from state, opReg, zero and memAck.
- FETCH
  - Drives memReq=1, iOrD=0.
  - On memAck: irWrite=1, pcWrite=1, pcSrc=00; next state DECODE.
- DECODE
  - Captures opcode into opReg.
  - 1111 (HLT): next state HALT.
  - 1101 (JMP): pcWrite=1, pcSrc=10; next state FETCH.
  - 1110 (JAL): pcWrite=1, pcSrc=10, regWrite=1, regDst=LINK_DST, memToReg=10; next state FETCH. The link value is PC+1, since the PC was already incremented in FETCH.
  - All other opcodes: next state EXEC.
- EXEC
  - Opcodes 0000–0111: aluOp=opReg[2:0], aluSrc1=00, aluSrc2=00; next state WB.
  - ADI (1000): aluOp=000, aluSrc2=01; next state WB.
  - SWP (1001): aluOp=000, aluSrc1=10, aluSrc2=10; next state WB.
  - LDW (1010) / STW (1011): aluOp=000, aluSrc2=01 (address calculation); next state MEM.
  - BRZ (1100): aluOp=001 (SUB Rs−Rt). If zero=1: pcWrite=1, pcSrc=01. Next state FETCH either way.
- MEM
  - Drives memReq=1, iOrD=1, memWe=(opReg==1011). The ALU controls from EXEC are held.
  - On memAck: LDW goes to WB; STW goes to FETCH.
- WB
  - Drives regWrite=1, regDst=00, and the ALU controls held from EXEC.
  - memToReg=01 for LDW, 00 otherwise.
  - Next state FETCH.
- retire pulses on every transition into FETCH, except from reset or FAULT, and on entry to HALT. instret increments with each pulse and wraps modulo 2^CNT_W.
- HALT and FAULT are absorbing states; only rst leaves them.

## Timing
- Reset
  - While rst=1, every output is 0, state=FETCH, instret=0 and the wait counter is 0.
  - The first cycle after reset is FETCH with memReq=1.
- Wait counter
  - Clears on entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle without memAck.
  - If the counter equals TIMEOUT and memAck=0, the next state is FAULT. When TIMEOUT ≠ 0, that is after TIMEOUT+1 unacked cycles.
  - If memAck arrives in that same cycle, memAck wins and no fault is raised.
- Latency with a zero-wait memory (memAck on the first req cycle):
  - ALU/ADI/SWP: 4 cycles.
  - LDW: 5 cycles.
  - STW: 4 cycles.
  - BRZ: 3 cycles.
  - JMP/JAL/HLT: 2 cycles.
  - Each memory wait cycle adds 1.
- memAck outside FETCH/MEM is ignored.
- A change on opcode after DECODE has no effect, because opReg is used from EXEC onward.
- rst asserted mid-MEM: memReq drops in the same cycle (outputs are combinationally gated). The next cycle is FETCH and nothing retires.

## Test plan
- ADD, zero-wait memory: state sequence 0,1,2,4,0. regWrite=1 only in WB, aluOp=000 in EXEC/WB, retire pulses once, instret=1.
- LDW, memAck delayed 3 cycles in MEM: memReq=1, iOrD=1, memWe=0 for 4 cycles, then WB with memToReg=01, regWrite=1. STW with the same delay: memWe=1, returns to FETCH with no regWrite.
- BRZ with zero=1: EXEC drives pcWrite=1, pcSrc=01. BRZ with zero=0: pcWrite=0. Both take 3 cycles.
- JAL: DECODE drives pcWrite=1, pcSrc=10, regWrite=1, regDst=10, memToReg=10. JMP: same PC signals with regWrite=0.
- TIMEOUT=4, memAck held at 0 in FETCH: fault=1 and state=6 after 5 FETCH cycles. With memAck asserted on the 5th cycle: no fault, next state DECODE.
- Opcode 1111: halted=1, instret increments, outputs stay idle for 20 cycles. Then rst asserted during an LDW MEM wait: all outputs 0, and the sequence resumes at FETCH with instret=0.
